pong_game_controller: RTL and testbench
=======================================

Name: pong_game_controller

Overview:
- Sequences one ball widget and two paddle widgets through serve, play, point and game-over phases.
- Gates each widget's per-frame enable.
- Issues a one-cycle reposition pulse to the widgets' reset inputs.
- Detects paddle hits and misses at the left/right play limits, keeps score and declares a winner.
- Sits between the VGA timing generator (frame tick) and the widget instances, feeding score digits to the overlay.

Parameters:
- WIN_SCORE, 7, points needed to win (1..15).
- SERVE_FRAMES, 60, frames the ball is held before release.
- POINT_FRAMES, 90, frames frozen after a point.
- LEFT_LIMIT, 0, ball X at or below this value is at the left wall.
- RIGHT_LIMIT, 799, ball right edge (ballX+ballSize) at or above this value is at the right wall.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-low reset.
- frameTick  in  1  one-clk pulse per frame (start of vertical blank).
- start  in  1  player start button, already synchronized.
- ballX, ballY  in  11 signed  ball top-left position.
- ballSize  in  9  ball width/height.
- leftPadY, rightPadY  in  11 signed  paddle top positions.
- padSizeY  in  9  paddle height.
- ballEnable  out  1  ball step strobe.
- paddleEnable  out  1  paddle step strobe.
- widgetReset  out  1  one-clk reposition pulse to all widgets.
- scoreLeft, scoreRight  out  4  scores.
- rally  out  8  hits in current rally.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- winner  out  2  00 none, 01 left, 10 right.
- flash  out  1  high in POINT and OVER for overlay blink.

Behaviour:
- Reset (reset low, async):
  - state=IDLE; scores, rally, frame counter, winner = 0.
  - widgetReset=0, flash=0, hit latches cleared, start edge register cleared.
- startEdge = start & ~start_q, with start_q registered every clk.
- ballEnable = frameTick & (state==PLAY). This is combinational, so widgets step once per frame.
- paddleEnable = frameTick & (state==SERVE or PLAY).
- widgetReset is registered. It is high for exactly the one clk after any transition into SERVE.
- IDLE: on startEdge, clear scores, rally and winner → SERVE.
- SERVE:
  - Frame counter clears on entry and increments on each frameTick.
  - When count == SERVE_FRAMES-1 and frameTick → PLAY; rally=0.
- PLAY: evaluated only on frameTick clocks.
  - Overlap(P) = (ballY+ballSize >= P) && (ballY <= P+padSizeY).
  - Comparisons use 12-bit signed intermediates; no wrap.
  - Left wall: ballX <= LEFT_LIMIT and hitL latch clear.
    - If Overlap(leftPadY): rally++ (saturates at 255), set hitL.
    - Otherwise: scoreRight++ → POINT.
  - hitL clears on the first frameTick with ballX > LEFT_LIMIT.
  - Right wall is symmetric: ballX+ballSize >= RIGHT_LIMIT, rightPadY, hitR, scoreLeft.
  - If both walls qualify in the same frame, only the left is evaluated.
  - startEdge is ignored in PLAY.
- POINT:
  - Counter clears on entry; flash=1.
  - After POINT_FRAMES frameTicks:
    - If either score == WIN_SCORE: set winner → OVER.
    - Otherwise → SERVE (widgetReset pulses).
- OVER: flash=1, scores and winner hold. startEdge → SERVE with scores, rally and winner cleared.
- Scores never exceed WIN_SCORE.
- frameTick outside SERVE/PLAY/POINT has no effect.
- reset low in any state aborts immediately; no widgetReset pulse is generated by the reset itself.

Test Plan:
- Reset, then start pulse → state=1 and widgetReset high exactly 1 clk. After 60 frameTicks → state=2 and rally=0.
- PLAY with ballX=0, ballY=200, ballSize=8, leftPadY=180, padSizeY=64, one frameTick → rally=1, state stays 2. Hold ballX=0 for 3 more frames → rally stays 1. Then ballX=50, then ballX=0 again → rally=2.
- PLAY with ballX=0, ballY=400, leftPadY=100 → scoreRight=1, state=3, flash=1. After 90 frames → state=1 with one widgetReset pulse.
- ballX=792, ballSize=8, rightPadY=0, ballY=300 → scoreLeft increments. Repeat until scoreLeft=7 → after POINT state=4, winner=01. Start pulse → scores 0, state=1.
- Assert reset low mid-PLAY with scores 3/2, asynchronously (not clock-aligned) → all outputs 0 and state=0 immediately. start held high across release → no SERVE until start falls and rises again.
- frameTick low throughout PLAY → ballEnable stays 0, scores and rally unchanged regardless of ballX.

Source files
------------

// File: rtl/pong_game_controller.sv
// Pong game sequencer: steps ball/paddle widgets per frame, judges wall hits and misses,
// keeps score and declares a winner.
module pong_game_controller #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int LEFT_LIMIT   = 0,
    parameter int RIGHT_LIMIT  = 799
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frameTick,
    input  logic               start,
    input  logic signed [10:0] ballX,
    input  logic signed [10:0] ballY,
    input  logic        [8:0]  ballSize,
    input  logic signed [10:0] leftPadY,
    input  logic signed [10:0] rightPadY,
    input  logic        [8:0]  padSizeY,
    output logic               ballEnable,
    output logic               paddleEnable,
    output logic               widgetReset,
    output logic        [3:0]  scoreLeft,
    output logic        [3:0]  scoreRight,
    output logic        [7:0]  rally,
    output logic        [2:0]  state,
    output logic        [1:0]  winner,
    output logic               flash
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [15:0]        SERVE_LAST = 16'(SERVE_FRAMES - 1);
    localparam logic [15:0]        POINT_LAST = 16'(POINT_FRAMES - 1);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
    localparam logic signed [11:0] LEFT_LIM   = 12'(LEFT_LIMIT);
    localparam logic signed [11:0] RIGHT_LIM  = 12'(RIGHT_LIMIT);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
    logic [7:0]  rally_q, rally_d;
    logic [1:0]  winner_q, winner_d;
    logic        hit_l_q, hit_l_d, hit_r_q, hit_r_d;
    logic        start_q, start_d, start_armed_q, start_armed_d;
    logic        widget_reset_q, widget_reset_d;

    logic signed [11:0] ball_x_s, ball_y_s, ball_size_s, pad_size_s;
    logic signed [11:0] left_pad_s, right_pad_s, ball_right_s, ball_bot_s;
    logic               at_left_s, at_right_s, ovl_left_s, ovl_right_s, start_edge_s;

    function automatic logic overlaps(input logic signed [11:0] top, input logic signed [11:0] bot,
                                      input logic signed [11:0] pad, input logic signed [11:0] pad_len);
        return (bot >= pad) && (top <= pad + pad_len);
    endfunction

    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s < WIN) ? s + 4'd1 : s;
    endfunction

    // Geometry in 12-bit signed space so sums never wrap.
    always_comb begin
        ball_x_s     = {ballX[10], ballX};
        ball_y_s     = {ballY[10], ballY};
        left_pad_s   = {leftPadY[10], leftPadY};
        right_pad_s  = {rightPadY[10], rightPadY};
        ball_size_s  = {3'b000, ballSize};
        pad_size_s   = {3'b000, padSizeY};
        ball_right_s = ball_x_s + ball_size_s;
        ball_bot_s   = ball_y_s + ball_size_s;
        at_left_s    = (ball_x_s <= LEFT_LIM);
        at_right_s   = (ball_right_s >= RIGHT_LIM);
        ovl_left_s   = overlaps(ball_y_s, ball_bot_s, left_pad_s, pad_size_s);
        ovl_right_s  = overlaps(ball_y_s, ball_bot_s, right_pad_s, pad_size_s);
        // A start held through reset must be released before it counts as a press.
        start_edge_s = start & ~start_q & start_armed_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 16'd0;
            score_l_q      <= 4'd0;
            score_r_q      <= 4'd0;
            rally_q        <= 8'd0;
            winner_q       <= 2'b00;
            hit_l_q        <= 1'b0;
            hit_r_q        <= 1'b0;
            start_q        <= 1'b0;
            start_armed_q  <= 1'b0;
            widget_reset_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            score_l_q      <= score_l_d;
            score_r_q      <= score_r_d;
            rally_q        <= rally_d;
            winner_q       <= winner_d;
            hit_l_q        <= hit_l_d;
            hit_r_q        <= hit_r_d;
            start_q        <= start_d;
            start_armed_q  <= start_armed_d;
            widget_reset_q <= widget_reset_d;
        end
    end

    // Next-state and scoring logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        rally_d       = rally_q;
        winner_d      = winner_q;
        hit_l_d       = hit_l_q;
        hit_r_d       = hit_r_q;
        start_d       = start;
        start_armed_d = start_armed_q | ~start;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge_s) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    rally_d   = 8'd0;
                    winner_d  = 2'b00;
                    state_d   = ST_SERVE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SERVE: begin
                if (frameTick && (cnt_q == SERVE_LAST)) begin
                    state_d = ST_PLAY;
                    rally_d = 8'd0;
                    cnt_d   = 16'd0;
                end else if (frameTick) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_PLAY: begin
                if (frameTick) begin
                    hit_l_d = at_left_s ? hit_l_q : 1'b0;
                    hit_r_d = at_right_s ? hit_r_q : 1'b0;
                    // Left wall wins when both qualify in the same frame.
                    if (at_left_s && !hit_l_q) begin
                        if (ovl_left_s) begin
                            rally_d = (rally_q == 8'hFF) ? rally_q : rally_q + 8'd1;
                            hit_l_d = 1'b1;
                        end else begin
                            score_r_d = score_inc(score_r_q);
                            state_d   = ST_POINT;
                            cnt_d     = 16'd0;
                        end
                    end else if (at_right_s && !hit_r_q) begin
                        if (ovl_right_s) begin
                            rally_d = (rally_q == 8'hFF) ? rally_q : rally_q + 8'd1;
                            hit_r_d = 1'b1;
                        end else begin
                            score_l_d = score_inc(score_l_q);
                            state_d   = ST_POINT;
                            cnt_d     = 16'd0;
                        end
                    end else begin
                        rally_d = rally_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_POINT: begin
                if (frameTick && (cnt_q == POINT_LAST)) begin
                    cnt_d = 16'd0;
                    if ((score_l_q == WIN) || (score_r_q == WIN)) begin
                        winner_d = (score_l_q == WIN) ? 2'b01 : 2'b10;
                        state_d  = ST_OVER;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end else if (frameTick) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        widget_reset_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
        if (widget_reset_d) begin
            cnt_d   = 16'd0;
            hit_l_d = 1'b0;
            hit_r_d = 1'b0;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Output decode.
    always_comb begin
        ballEnable   = frameTick & (state_q == ST_PLAY);
        paddleEnable = frameTick & ((state_q == ST_SERVE) || (state_q == ST_PLAY));
        flash        = (state_q == ST_POINT) || (state_q == ST_OVER);
        widgetReset  = widget_reset_q;
        scoreLeft    = score_l_q;
        scoreRight   = score_r_q;
        rally        = rally_q;
        state        = state_q;
        winner       = winner_q;
    end

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed bench for pong_game_controller: serve, hits, misses, win, async reset, idle frames.
module tb_pong_game_controller;

    logic               clk = 1'b0;
    logic               reset, frameTick, start;
    logic signed [10:0] ballX, ballY, leftPadY, rightPadY;
    logic        [8:0]  ballSize, padSizeY;
    logic               ballEnable, paddleEnable, widgetReset, flash;
    logic        [3:0]  scoreLeft, scoreRight;
    logic        [7:0]  rally;
    logic        [2:0]  state;
    logic        [1:0]  winner;

    int n_checks = 0;
    int n_errors = 0;

    pong_game_controller dut (
        .clk(clk), .reset(reset), .frameTick(frameTick), .start(start),
        .ballX(ballX), .ballY(ballY), .ballSize(ballSize),
        .leftPadY(leftPadY), .rightPadY(rightPadY), .padSizeY(padSizeY),
        .ballEnable(ballEnable), .paddleEnable(paddleEnable), .widgetReset(widgetReset),
        .scoreLeft(scoreLeft), .scoreRight(scoreRight), .rally(rally),
        .state(state), .winner(winner), .flash(flash)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frameTick = 1'b1;
            @(negedge clk) frameTick = 1'b0;
        end
    endtask

    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic serve_to_play();
        ballX = 11'sd400;
        @(negedge clk) frameTick = 1'b1;
        #1;
        check_val("serve_paddle_en", paddleEnable, 1);
        check_val("serve_ball_en", ballEnable, 0);
        @(negedge clk) frameTick = 1'b0;
        frames(58);
        check_val("serve_hold", state, 1);
        frames(1);
        check_val("serve_release", state, 2);
        check_val("serve_rally", rally, 0);
    endtask

    task automatic score_point(input bit left_scorer);
        serve_to_play();
        if (left_scorer) begin
            ballX = 11'sd792; ballY = 11'sd300; rightPadY = 11'sd0;
        end else begin
            ballX = 11'sd0; ballY = 11'sd400; leftPadY = 11'sd100;
        end
        frames(1);
        check_val("point_state", state, 3);
        ballX = 11'sd400;
        frames(90);
    endtask

    initial begin
        reset = 1'b0; frameTick = 1'b0; start = 1'b0;
        ballX = 11'sd400; ballY = 11'sd200; ballSize = 9'd8;
        leftPadY = 11'sd180; rightPadY = 11'sd0; padSizeY = 9'd64;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_state", state, 0);
        check_val("rst_score_l", scoreLeft, 0);
        check_val("rst_score_r", scoreRight, 0);
        check_val("rst_wreset", widgetReset, 0);
        check_val("rst_flash", flash, 0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);

        start_pulse();
        check_val("start_state", state, 1);
        check_val("start_wreset", widgetReset, 1);
        @(negedge clk);
        check_val("start_wreset_one", widgetReset, 0);
        serve_to_play();

        // Left paddle hit, latch holds while ball stays at the wall.
        ballX = 11'sd0; ballY = 11'sd200; leftPadY = 11'sd180;
        @(negedge clk) frameTick = 1'b1;
        #1;
        check_val("play_ball_en", ballEnable, 1);
        @(negedge clk) frameTick = 1'b0;
        check_val("hit_l_rally", rally, 1);
        check_val("hit_l_state", state, 2);
        frames(3);
        check_val("hit_l_latched", rally, 1);
        ballX = 11'sd50; frames(1);
        ballX = 11'sd0;  frames(1);
        check_val("hit_l_again", rally, 2);

        // Left miss.
        ballX = 11'sd50; frames(1);
        ballX = 11'sd0; ballY = 11'sd400; leftPadY = 11'sd100;
        frames(1);
        check_val("miss_l_score_r", scoreRight, 1);
        check_val("miss_l_score_l", scoreLeft, 0);
        check_val("miss_l_state", state, 3);
        check_val("miss_l_flash", flash, 1);
        ballX = 11'sd400;
        frames(89);
        check_val("point_hold", state, 3);
        frames(1);
        check_val("point_to_serve", state, 1);
        check_val("point_wreset", widgetReset, 1);
        @(negedge clk);
        check_val("point_wreset_one", widgetReset, 0);

        // Right paddle hit, then right miss.
        serve_to_play();
        ballX = 11'sd792; ballY = 11'sd20; rightPadY = 11'sd0;
        frames(1);
        check_val("hit_r_rally", rally, 1);
        ballY = 11'sd300; frames(1);
        check_val("hit_r_latched", rally, 1);
        check_val("hit_r_no_score", scoreLeft, 0);
        ballX = 11'sd400; frames(1);
        ballX = 11'sd792; frames(1);
        check_val("miss_r_score_l", scoreLeft, 1);
        check_val("miss_r_state", state, 3);
        ballX = 11'sd400; frames(90);
        check_val("miss_r_serve", state, 1);

        for (int i = 2; i <= 7; i++) begin
            score_point(1'b1);
            check_val("score_l_run", scoreLeft, i);
        end
        check_val("over_state", state, 4);
        check_val("over_winner", winner, 1);
        check_val("over_flash", flash, 1);
        check_val("over_score_r", scoreRight, 1);
        frames(3);
        check_val("over_frames_ignored", state, 4);
        check_val("over_score_hold", scoreLeft, 7);
        start_pulse();
        check_val("restart_state", state, 1);
        check_val("restart_score_l", scoreLeft, 0);
        check_val("restart_score_r", scoreRight, 0);
        check_val("restart_winner", winner, 0);
        check_val("restart_wreset", widgetReset, 1);

        // Build a 3/2 score, then async reset mid-rally.
        for (int i = 0; i < 3; i++) score_point(1'b1);
        for (int i = 0; i < 2; i++) score_point(1'b0);
        serve_to_play();
        check_val("mid_score_l", scoreLeft, 3);
        check_val("mid_score_r", scoreRight, 2);
        ballX = 11'sd0; ballY = 11'sd200; leftPadY = 11'sd180;
        frames(1);
        check_val("mid_rally", rally, 1);
        @(posedge clk);
        #3 reset = 1'b0; start = 1'b1;
        #1;
        check_val("arst_state", state, 0);
        check_val("arst_score_l", scoreLeft, 0);
        check_val("arst_score_r", scoreRight, 0);
        check_val("arst_rally", rally, 0);
        check_val("arst_winner", winner, 0);
        check_val("arst_flash", flash, 0);
        check_val("arst_wreset", widgetReset, 0);
        @(negedge clk) reset = 1'b1;
        repeat (5) @(negedge clk);
        check_val("held_start_ignored", state, 0);
        start = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_val("restart_after_rst", state, 1);

        // No frame ticks in PLAY: nothing moves.
        serve_to_play();
        ballX = 11'sd0; ballY = 11'sd400; leftPadY = 11'sd100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("no_tick_ball_en", ballEnable, 0);
        end
        check_val("no_tick_state", state, 2);
        check_val("no_tick_score_r", scoreRight, 0);
        check_val("no_tick_rally", rally, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
